// File: rtl/pingala_engine_arbiter.sv
// pingala_engine_arbiter: round-robin sequencer that shares one pingala_binary
// engine among NUM_REQ requesters. One operation is in flight at a time. Each
// result is returned with the ID of the requester that asked for it, and a
// watchdog aborts an operation whose engine never reports done.
module pingala_engine_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_N      = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  input  logic [4*NUM_REQ-1:0]          req_n,
  input  logic [MAX_N*NUM_REQ-1:0]      req_pattern,
  output logic [2:0]                    eng_operation,
  output logic [DATA_WIDTH-1:0]         eng_input_data,
  output logic [3:0]                    eng_n_value,
  output logic [MAX_N-1:0]              eng_laghu_guru,
  output logic                          eng_start,
  input  logic                          eng_busy,
  input  logic                          eng_done,
  input  logic [DATA_WIDTH-1:0]         eng_result,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_timeout,
  input  logic                          rsp_ready
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic [ID_W-1:0]       ptr_q,     ptr_d;
  logic [ID_W-1:0]       id_q,      id_d;
  logic [TMR_W-1:0]      tmr_q,     tmr_d;
  logic [NUM_REQ-1:0]    ready_q,   ready_d;
  logic [2:0]            op_q,      op_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic [3:0]            n_q,       n_d;
  logic [MAX_N-1:0]      pat_q,     pat_d;
  logic                  start_q,   start_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                  rtmo_q,    rtmo_d;

  // Per-requester views of the packed request fields
  logic [2:0]            op_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [3:0]            n_arr    [NUM_REQ];
  logic [MAX_N-1:0]      pat_arr  [NUM_REQ];

  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  int unsigned           cand;
  int unsigned           ptr_inc;

  // Unpack the flat request buses into per-requester arrays
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_arr[i]   = req_op[3*i +: 3];
      data_arr[i] = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      n_arr[i]    = req_n[4*i +: 4];
      pat_arr[i]  = req_pattern[MAX_N*i +: MAX_N];
    end
  end

  // Round-robin search: first valid requester at or after ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    tmr_d    = tmr_q;
    ready_d  = '0;
    op_d     = op_q;
    data_d   = data_q;
    n_d      = n_q;
    pat_d    = pat_q;
    start_d  = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rtmo_d   = rtmo_q;
    ptr_inc  = 32'(id_q) + 1;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          ready_d = NUM_REQ'(1) << grant_idx;
          id_d    = grant_idx;
          op_d    = op_arr[grant_idx];
          data_d  = data_arr[grant_idx];
          n_d     = n_arr[grant_idx];
          pat_d   = pat_arr[grant_idx];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Hold off the start pulse while the engine is still busy
        if (!eng_busy) begin
          start_d = 1'b1;
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done pulse wins over a coincident watchdog expiry
        if (eng_done) begin
          rdata_d  = eng_result;
          rtmo_d   = 1'b0;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else if (tmr_q >= TMR_W'(TIMEOUT - 1)) begin
          rdata_d  = '0;
          rtmo_d   = 1'b1;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_RESP: begin
        if (rvalid_q && rsp_ready) begin
          rvalid_d = 1'b0;
          ptr_d    = (ptr_inc >= NUM_REQ) ? '0 : ID_W'(ptr_inc);
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      tmr_q    <= '0;
      ready_q  <= '0;
      op_q     <= '0;
      data_q   <= '0;
      n_q      <= '0;
      pat_q    <= '0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rtmo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      tmr_q    <= tmr_d;
      ready_q  <= ready_d;
      op_q     <= op_d;
      data_q   <= data_d;
      n_q      <= n_d;
      pat_q    <= pat_d;
      start_q  <= start_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rtmo_q   <= rtmo_d;
    end
  end

  assign req_ready      = ready_q;
  assign eng_operation  = op_q;
  assign eng_input_data = data_q;
  assign eng_n_value    = n_q;
  assign eng_laghu_guru = pat_q;
  assign eng_start      = start_q;
  assign rsp_valid      = rvalid_q;
  assign rsp_id         = id_q;
  assign rsp_data       = rdata_q;
  assign rsp_timeout    = rtmo_q;

endmodule

// File: tb/tb_pingala_engine_arbiter.sv
// Directed bench for pingala_engine_arbiter; the engine side is driven by hand.
module tb_pingala_engine_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MN = 16;
  localparam int unsigned TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [3*NR-1:0]  req_op;
  logic [DW*NR-1:0] req_data;
  logic [4*NR-1:0]  req_n;
  logic [MN*NR-1:0] req_pattern;
  logic [2:0]       eng_operation;
  logic [DW-1:0]    eng_input_data;
  logic [3:0]       eng_n_value;
  logic [MN-1:0]    eng_laghu_guru;
  logic             eng_start;
  logic             eng_busy;
  logic             eng_done;
  logic [DW-1:0]    eng_result;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             rsp_timeout;
  logic             rsp_ready;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;
  int s0;

  pingala_engine_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_N(MN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_n(req_n), .req_pattern(req_pattern),
    .eng_operation(eng_operation), .eng_input_data(eng_input_data),
    .eng_n_value(eng_n_value), .eng_laghu_guru(eng_laghu_guru),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_result(eng_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and tally start pulses
  task automatic step();
    @(posedge clk);
    #1;
    if (eng_start === 1'b1) start_cnt++;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] d,
                         input logic [3:0] n, input logic [15:0] p);
    req_op[3*i +: 3]       = op;
    req_data[DW*i +: DW]   = d;
    req_n[4*i +: 4]        = n;
    req_pattern[MN*i +: MN] = p;
  endtask

  task automatic wait_ready(input string tag, input logic [3:0] exp);
    int n = 0;
    while (req_ready === '0 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(req_ready), 64'(exp));
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (eng_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(eng_start), 64'd1);
  endtask

  // Engine reports done with the given result for one cycle
  task automatic finish_op(input logic [31:0] r);
    eng_done   = 1'b1;
    eng_result = r;
    step();
    eng_done   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0; req_n = '0;
    req_pattern = '0; eng_busy = 1'b0; eng_done = 1'b0; eng_result = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_eng_op", 64'(eng_operation), 64'd0);
    rst = 1'b0;

    // All requesters valid: grants rotate 0,1,2,3,0 with one start each
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 32'h10 + 32'(i), 4'(i + 2), 16'h100 + 16'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s0 = start_cnt;
      wait_ready($sformatf("rr_grant%0d", k), 4'(1 << (k % 4)));
      if (k == 4) req_valid = '0;
      wait_start($sformatf("rr_start%0d", k));
      finish_op(32'd100 + 32'(k));
      chk($sformatf("rr_rsp_id%0d", k), 64'(rsp_id), 64'(k % 4));
      chk($sformatf("rr_rsp_data%0d", k), 64'(rsp_data), 64'd100 + 64'(k));
      step();
      chk($sformatf("rr_starts%0d", k), 64'(start_cnt - s0), 64'd1);
    end

    // Single requester 2: op 3, n 4, data 2, engine returns 6
    rsp_ready = 1'b0;
    set_req(2, 3'd3, 32'd2, 4'd4, 16'hA5A5);
    req_valid = 4'b0100;
    wait_ready("t1_ready", 4'b0100);
    req_valid = '0;
    step();
    chk("t1_ready_pulse", 64'(req_ready), 64'd0);
    chk("t1_start", 64'(eng_start), 64'd1);
    chk("t1_op", 64'(eng_operation), 64'd3);
    chk("t1_n", 64'(eng_n_value), 64'd4);
    chk("t1_data", 64'(eng_input_data), 64'd2);
    chk("t1_pattern", 64'(eng_laghu_guru), 64'hA5A5);
    step();
    chk("t1_start_once", 64'(eng_start), 64'd0);
    finish_op(32'd6);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_id", 64'(rsp_id), 64'd2);
    chk("t1_rsp_data", 64'(rsp_data), 64'd6);
    chk("t1_rsp_tmo", 64'(rsp_timeout), 64'd0);
    rsp_ready = 1'b1;
    step();
    chk("t1_rsp_drop", 64'(rsp_valid), 64'd0);

    // Watchdog: engine never answers; abort after TIMEOUT cycles in WAIT
    rsp_ready = 1'b0;
    set_req(0, 3'd7, 32'hDEAD, 4'd9, 16'h0F0F);
    req_valid = 4'b0001;
    wait_ready("t3_ready", 4'b0001);
    req_valid = '0;
    wait_start("t3_start");
    chk("t3_op7_passthru", 64'(eng_operation), 64'd7);
    repeat (TO - 1) step();
    chk("t3_not_yet", 64'(rsp_valid), 64'd0);
    step();
    chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t3_rsp_tmo", 64'(rsp_timeout), 64'd1);
    chk("t3_rsp_data", 64'(rsp_data), 64'd0);
    chk("t3_rsp_id", 64'(rsp_id), 64'd0);
    finish_op(32'hBAD);
    chk("t3_stray_data", 64'(rsp_data), 64'd0);
    chk("t3_stray_tmo", 64'(rsp_timeout), 64'd1);
    rsp_ready = 1'b1;
    step();
    chk("t3_rsp_drop", 64'(rsp_valid), 64'd0);

    // Backpressure: response held stable, no accept or start meanwhile
    rsp_ready = 1'b0;
    set_req(1, 3'd5, 32'hABCD, 4'd7, 16'h1111);
    set_req(3, 3'd2, 32'h77, 4'd3, 16'h2222);
    req_valid = 4'b0010;
    wait_ready("t4_ready", 4'b0010);
    req_valid = 4'b1000;
    wait_start("t4_start");
    finish_op(32'h1234);
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t4_rsp_id", 64'(rsp_id), 64'd1);
    s0 = start_cnt;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("t4_hold_valid%0d", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("t4_hold_id%0d", c), 64'(rsp_id), 64'd1);
      chk($sformatf("t4_hold_data%0d", c), 64'(rsp_data), 64'h1234);
      chk($sformatf("t4_hold_ready%0d", c), 64'(req_ready), 64'd0);
    end
    chk("t4_no_start", 64'(start_cnt - s0), 64'd0);
    rsp_ready = 1'b1;
    step();
    wait_ready("t4_next_grant", 4'b1000);

    // Engine busy for 3 cycles at issue delays the single start pulse
    req_valid = '0;
    eng_busy  = 1'b1;
    s0 = start_cnt;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t5_busy_nostart%0d", c), 64'(eng_start), 64'd0);
    end
    eng_busy = 1'b0;
    step();
    chk("t5_start", 64'(eng_start), 64'd1);
    chk("t5_op", 64'(eng_operation), 64'd2);
    step();
    chk("t5_start_once", 64'(eng_start), 64'd0);
    finish_op(32'h55);
    chk("t5_rsp_id", 64'(rsp_id), 64'd3);
    chk("t5_rsp_data", 64'(rsp_data), 64'h55);
    chk("t5_starts", 64'(start_cnt - s0), 64'd1);
    step();

    // Reset during WAIT: asynchronous clear, no response, lowest grant next
    set_req(1, 3'd6, 32'h99, 4'd1, 16'h3333);
    req_valid = 4'b1010;
    wait_ready("t6_ready", 4'b0010);
    wait_start("t6_start");
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_op", 64'(eng_operation), 64'd0);
    chk("t6_async_data", 64'(eng_input_data), 64'd0);
    chk("t6_async_valid", 64'(rsp_valid), 64'd0);
    chk("t6_async_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    wait_ready("t6_first_grant", 4'b0010);
    chk("t6_no_rsp", 64'(rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
